// File: rtl/adder_result_stage.sv
// Registered result stage behind the 64-bit adder: captures sum/carry, derives flags and
// buffers entries in an in-order FIFO. Optional counters are enabled by ADDER_RESULT_STATS_EN.
module adder_result_stage #(
    parameter int WIDTH = 64,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic [WIDTH-1:0] in_sum,
    input  logic             in_carry_out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_carry,
    output logic             out_zero,
    output logic             out_neg,
    output logic             out_ovf
`ifdef ADDER_RESULT_STATS_EN
    ,
    output logic [31:0]      stat_results,
    output logic [31:0]      stat_carries,
    output logic [31:0]      stat_ovfs
`endif
);

    // Handshake: a transfer happens on a rising edge where valid & ready are both high;
    // ready never depends on valid, and valid/data hold steady until the transfer occurs.

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);
    localparam logic [AW-1:0] LAST_PTR   = AW'(DEPTH - 1);

    logic [WIDTH-1:0] sum_mem  [DEPTH];
    logic [3:0]       flag_mem [DEPTH];   // {ovf, neg, zero, carry}
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;

    logic             push;
    logic             pop;
    logic             flag_zero;
    logic             flag_neg;
    logic             flag_ovf;
    logic             operand_unused;

    // Only the operand sign bits feed the flags.
    assign operand_unused = ^{in_a[WIDTH-2:0], in_b[WIDTH-2:0]};

    always_comb begin
        flag_zero = ~|in_sum;
        flag_neg  = in_sum[WIDTH-1];
        flag_ovf  = (in_a[WIDTH-1] == in_b[WIDTH-1]) & (in_sum[WIDTH-1] != in_a[WIDTH-1]);
    end

    assign in_ready  = (count != FULL_COUNT);
    assign out_valid = (count != '0);
    assign push      = in_valid & in_ready;
    assign pop       = out_valid & out_ready;

    assign out_sum   = sum_mem[rd_ptr];
    assign out_carry = flag_mem[rd_ptr][0];
    assign out_zero  = flag_mem[rd_ptr][1];
    assign out_neg   = flag_mem[rd_ptr][2];
    assign out_ovf   = flag_mem[rd_ptr][3];

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                sum_mem[i]  <= '0;
                flag_mem[i] <= '0;
            end
        end else begin
            if (push) begin
                sum_mem[wr_ptr]  <= in_sum;
                flag_mem[wr_ptr] <= {flag_ovf, flag_neg, flag_zero, in_carry_out};
                wr_ptr           <= (wr_ptr == LAST_PTR) ? '0 : wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= (rd_ptr == LAST_PTR) ? '0 : rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef ADDER_RESULT_STATS_EN
    // Counters saturate rather than wrap so a long run never reports a small value.
    always_ff @(posedge clk) begin
        if (rst) begin
            stat_results <= '0;
            stat_carries <= '0;
            stat_ovfs    <= '0;
        end else if (push) begin
            if (stat_results != '1) stat_results <= stat_results + 32'd1;
            if (in_carry_out && (stat_carries != '1)) stat_carries <= stat_carries + 32'd1;
            if (flag_ovf && (stat_ovfs != '1)) stat_ovfs <= stat_ovfs + 32'd1;
        end
    end
`endif

endmodule
